// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI slave definitions: response codes, ID width and FSM state encodings.
package axi_sram_slave_pkg;

    localparam int ID_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RAM  = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RAM  = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_slv_ram.sv
// Single-port 32-bit RAM with per-byte write enable, synchronous write and registered read.
module axi_slv_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-lane writes; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered read port, holds its value while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'd0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 SRAM responder; one outstanding read and write, bursts answered with SLVERR.
// Optional response delay: define AXI_SLV_DELAY_EN to insert RESP_DELAY wait cycles.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter int RESP_DELAY = 2
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic [1:0]      arlock,
    input  logic [3:0]      arcache,
    input  logic [2:0]      arprot,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic [1:0]      awlock,
    input  logic [3:0]      awcache,
    input  logic [2:0]      awprot,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    localparam logic [7:0] RESP_DLY = 8'(RESP_DELAY);

    r_state_t          r_state_r, r_state_s;
    w_state_t          w_state_r, w_state_s;
    logic              ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
    logic              r_stall_s, r_load_s, b_load_s, ram_rd_s, ram_wr_s;
    logic              aw_got_s, w_got_s, aw_held_s, w_held_s;
    logic              aw_held_r, w_held_r;
    logic [MEM_AW-1:0] r_idx_r, w_idx_r, ram_addr_s;
    logic              r_err_r, w_err_r;
    logic [ID_W-1:0]   rid_r, awid_r, bid_r;
    logic [31:0]       wdata_r, rdata_r, ram_q_s;
    logic [3:0]        wstrb_r, ram_we_s;
    logic              arready_r, awready_r, wready_r, rvalid_r, rlast_r, bvalid_r;
    logic [1:0]        rresp_r, bresp_r;
`ifdef AXI_SLV_DELAY_EN
    logic [7:0]        r_cnt_r, w_cnt_r;
`endif

    logic unused_s;
    assign unused_s = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0],
                        arsize, arburst, arlock, arcache, arprot,
                        awsize, awburst, awlock, awcache, awprot, wid, wlast, RESP_DLY};

    assign ar_hs_s  = arvalid && arready_r;
    assign r_hs_s   = rvalid_r && rready;
    assign aw_hs_s  = awvalid && awready_r;
    assign w_hs_s   = wvalid && wready_r;
    assign b_hs_s   = bvalid_r && bready;
    assign aw_got_s = aw_held_r || aw_hs_s;
    assign w_got_s  = w_held_r || w_hs_s;
    // The write owns the single RAM port whenever it is in W_RAM.
    assign r_stall_s = (w_state_r == W_RAM);

    // FSM state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r <= R_IDLE;
            w_state_r <= W_IDLE;
        end else begin
            r_state_r <= r_state_s;
            w_state_r <= w_state_s;
        end
    end

    // Read next-state logic.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_s = R_RAM;
                else         r_state_s = R_IDLE;
            end
            R_RAM: begin
                if (r_stall_s) begin
                    r_state_s = R_RAM;
                end else begin
`ifdef AXI_SLV_DELAY_EN
                    if (RESP_DLY != 8'd0) r_state_s = R_WAIT;
                    else                  r_state_s = R_RESP;
`else
                    r_state_s = R_RESP;
`endif
                end
            end
            R_WAIT: begin
`ifdef AXI_SLV_DELAY_EN
                if (r_cnt_r <= 8'd1) r_state_s = R_RESP;
                else                 r_state_s = R_WAIT;
`else
                r_state_s = R_IDLE;
`endif
            end
            R_RESP: begin
                if (r_hs_s) r_state_s = R_IDLE;
                else        r_state_s = R_RESP;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Write next-state logic.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_got_s && w_got_s) w_state_s = W_RAM;
                else                     w_state_s = W_IDLE;
            end
            W_RAM: begin
`ifdef AXI_SLV_DELAY_EN
                if (RESP_DLY != 8'd0) w_state_s = W_WAIT;
                else                  w_state_s = W_RESP;
`else
                w_state_s = W_RESP;
`endif
            end
            W_WAIT: begin
`ifdef AXI_SLV_DELAY_EN
                if (w_cnt_r <= 8'd1) w_state_s = W_RESP;
                else                 w_state_s = W_WAIT;
`else
                w_state_s = W_IDLE;
`endif
            end
            W_RESP: begin
                if (b_hs_s) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Output decode: RAM controls, response loads and captured-channel flags.
    always_comb begin
        ram_rd_s   = (r_state_r == R_RAM) && !r_stall_s;
        ram_wr_s   = (w_state_r == W_RAM) && !w_err_r;
        ram_we_s   = ram_wr_s ? wstrb_r : 4'd0;
        ram_addr_s = (w_state_r == W_RAM) ? w_idx_r : r_idx_r;
        r_load_s   = (r_state_r == R_RESP) && !rvalid_r;
        b_load_s   = (w_state_r == W_RESP) && !bvalid_r;
        if (w_state_r == W_IDLE) begin
            aw_held_s = aw_got_s;
            w_held_s  = w_got_s;
        end else if (w_state_s == W_IDLE) begin
            aw_held_s = 1'b0;
            w_held_s  = 1'b0;
        end else begin
            aw_held_s = aw_held_r;
            w_held_s  = w_held_r;
        end
    end

`ifdef AXI_SLV_DELAY_EN
    // Response delay counters, loaded on leaving the RAM states.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt_r <= 8'd0;
            w_cnt_r <= 8'd0;
        end else begin
            if (r_state_r == R_RAM && !r_stall_s) r_cnt_r <= RESP_DLY;
            else if (r_state_r == R_WAIT)         r_cnt_r <= r_cnt_r - 8'd1;
            if (w_state_r == W_RAM)               w_cnt_r <= RESP_DLY;
            else if (w_state_r == W_WAIT)         w_cnt_r <= w_cnt_r - 8'd1;
        end
    end
`endif

    // Request capture on address/data handshakes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid_r     <= '0;
            r_idx_r   <= '0;
            r_err_r   <= 1'b0;
            awid_r    <= '0;
            w_idx_r   <= '0;
            w_err_r   <= 1'b0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                rid_r   <= arid;
                r_idx_r <= araddr[MEM_AW+1:2];
                r_err_r <= (arlen != 8'd0);
            end
            if (aw_hs_s) begin
                awid_r  <= awid;
                w_idx_r <= awaddr[MEM_AW+1:2];
                w_err_r <= (awlen != 8'd0);
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            aw_held_r <= aw_held_s;
            w_held_r  <= w_held_s;
        end
    end

    // Registered channel outputs; responses stay frozen until their handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready_r <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 32'd0;
            rresp_r   <= 2'b00;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= 2'b00;
        end else begin
            arready_r <= (r_state_s == R_IDLE);
            awready_r <= (w_state_s == W_IDLE) && !aw_held_s;
            wready_r  <= (w_state_s == W_IDLE) && !w_held_s;
            if (r_load_s) begin
                rvalid_r <= 1'b1;
                rlast_r  <= 1'b1;
                rdata_r  <= ram_q_s;
                rresp_r  <= resp_of(r_err_r);
            end else if (r_hs_s) begin
                rvalid_r <= 1'b0;
                rlast_r  <= 1'b0;
            end
            if (b_load_s) begin
                bvalid_r <= 1'b1;
                bid_r    <= awid_r;
                bresp_r  <= resp_of(w_err_r);
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    axi_slv_ram #(.AW(MEM_AW)) u_ram (
        .clk   (aclk),
        .rst_n (aresetn),
        .re    (ram_rd_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_q_s)
    );

    assign arready = arready_r;
    assign awready = awready_r;
    assign wready  = wready_r;
    assign rid     = rid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign rlast   = rlast_r;
    assign rvalid  = rvalid_r;
    assign bid     = bid_r;
    assign bresp   = bresp_r;
    assign bvalid  = bvalid_r;

endmodule
